stage_sequencer: RTL and testbench

Parametrised multi-cycle sequencer for the single-issue core. It drives the IFU, IDU, EXU and LSU through one instruction at a time using start/done handshakes, so any stage may take a variable number of cycles. The decoder selects whether the optional MEM stage runs. A per-stage watchdog detects stages that never finish. The block also owns arbitration of the shared memory port, the writeback commit pulse, and the trap/halt status reported to the simulation environment.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_watchdog.sv | 27 ++
 rtl/stage_sequencer.sv | 170 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the stage sequencer: FSM states and trap causes.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_FAULT   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog. Counts cycles while en is high and flags expiry in the
// cycle that would be the (2^TO_W-1)-th counted cycle, so a done arriving in
// that same cycle (en low) still wins over the timeout.
module seq_watchdog #(
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count value seen during the last permitted cycle: 2^TO_W-2.
  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt_q;

  // Cycle counter, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle sequencer for the single-issue core: walks one instruction
// through fetch/decode/execute/(mem)/writeback using start/done handshakes,
// owns the shared memory port select, the commit pulse and trap/halt status.
// Optional performance counters are built when STAGE_SEQ_PERF_EN is defined;
// otherwise cycle_cnt and instret read as zero.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic             ifu_start,
  input  logic             ifu_done,
  output logic             idu_start,
  input  logic             idu_done,
  input  logic             idu_need_mem,
  input  logic             idu_illegal,
  output logic             exu_start,
  input  logic             exu_done,
  input  logic             ebreak,
  output logic             lsu_start,
  input  logic             lsu_done,
  input  logic             lsu_fault,
  output logic             mem_owner,
  output logic             wb_en,
  output logic             halted,
  output logic             good_trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  state_e     state_q, state_d;
  logic       first_q;       // high in the first cycle of each state
  logic       need_mem_q;
  logic       halted_q, good_trap_q;
  logic [1:0] cause_q;

  logic       halt_go, good_d;
  logic [1:0] cause_d;
  logic       stage_done, wd_en, wd_clr, wd_exp;

  // The done input that belongs to the current state; others are ignored.
  always_comb begin
    stage_done = 1'b0;
    unique case (state_q)
      ST_FETCH:  stage_done = ifu_done;
      ST_DECODE: stage_done = idu_done;
      ST_EXEC:   stage_done = exu_done;
      ST_MEM:    stage_done = lsu_done;
      default:   stage_done = 1'b0;
    endcase
  end

  assign wd_en  = (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM}) && !stage_done;
  assign wd_clr = (state_d != state_q);

  seq_watchdog #(.TO_W(TO_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  // Next-state and trap selection; flags sampled with done beat normal flow.
  always_comb begin
    state_d = state_q;
    halt_go = 1'b0;
    good_d  = 1'b0;
    cause_d = CAUSE_EBREAK;
    unique case (state_q)
      ST_INIT: if (!stall) state_d = ST_FETCH;
      ST_FETCH: begin
        if (ifu_done) state_d = ST_DECODE;
        else if (wd_exp) begin
          state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (idu_done) begin
          if (idu_illegal) begin
            state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_ILLEGAL;
          end else state_d = ST_EXEC;
        end else if (wd_exp) begin
          state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (exu_done) begin
          if (ebreak) begin
            state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_EBREAK; good_d = 1'b1;
          end else state_d = need_mem_q ? ST_MEM : ST_WB;
        end else if (wd_exp) begin
          state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_MEM: begin
        if (lsu_done) begin
          if (lsu_fault) begin
            state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_FAULT;
          end else state_d = ST_WB;
        end else if (wd_exp) begin
          state_d = ST_HALT; halt_go = 1'b1; cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB:   state_d = ST_INIT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  // State, first-cycle flag, latched mem request and sticky trap status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      first_q     <= 1'b0;
      need_mem_q  <= 1'b0;
      halted_q    <= 1'b0;
      good_trap_q <= 1'b0;
      cause_q     <= CAUSE_EBREAK;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      if (state_q == ST_DECODE && idu_done) need_mem_q <= idu_need_mem;
      if (halt_go) begin
        halted_q    <= 1'b1;
        good_trap_q <= good_d;
        cause_q     <= cause_d;
      end
    end
  end

  assign ifu_start  = first_q && (state_q == ST_FETCH);
  assign idu_start  = first_q && (state_q == ST_DECODE);
  assign exu_start  = first_q && (state_q == ST_EXEC);
  assign lsu_start  = first_q && (state_q == ST_MEM);
  assign mem_owner  = (state_q == ST_MEM);
  assign wb_en      = (state_q == ST_WB);
  assign halted     = halted_q;
  assign good_trap  = good_trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

`ifdef STAGE_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  // Free-running cycle and retire counters; both freeze once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (!halted_q) cyc_q <= cyc_q + 1'b1;
      if (wb_en)     ret_q <= ret_q + 1'b1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ret_q;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a per-cycle vector table for the main
// instruction flow plus hand-written sequences for traps, watchdog and reset.
module tb_stage_sequencer;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        ifu_done = 0, idu_done = 0, idu_need_mem = 0, idu_illegal = 0;
  logic        exu_done = 0, ebreak = 0, lsu_done = 0, lsu_fault = 0;
  logic        ifu_start, idu_start, exu_start, lsu_start, mem_owner, wb_en;
  logic        halted, good_trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt, instret;

  always #5 clk = ~clk;

  stage_sequencer #(.CNT_W(32), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ifu_start(ifu_start), .ifu_done(ifu_done),
    .idu_start(idu_start), .idu_done(idu_done),
    .idu_need_mem(idu_need_mem), .idu_illegal(idu_illegal),
    .exu_start(exu_start), .exu_done(exu_done), .ebreak(ebreak),
    .lsu_start(lsu_start), .lsu_done(lsu_done), .lsu_fault(lsu_fault),
    .mem_owner(mem_owner), .wb_en(wb_en), .halted(halted),
    .good_trap(good_trap), .trap_cause(trap_cause), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  // inputs: {stall, ifd, idd, need_mem, illegal, exd, ebreak, lsd, fault}
  // exp:    {state[2:0], ifs, ids, exs, lss, wb, mem_owner, halted}
  typedef struct packed {
    logic [8:0] in;
    logic [9:0] exp;
    logic [3:0] ret;
  } vec_t;

  vec_t tbl [23];
  int   n_chk = 0, n_pass = 0, wb_seen = 0;
  bit   perf;

  always @(posedge clk) if (wb_en) wb_seen++;

  function automatic vec_t mk(logic [8:0] in, logic [2:0] st, logic [6:0] o, logic [3:0] r);
    vec_t v;
    v.in = in; v.exp = {st, o}; v.ret = r;
    return v;
  endfunction

  function automatic logic [9:0] outs10();
    return {state_o, ifu_start, idu_start, exu_start, lsu_start, wb_en, mem_owner, halted};
  endfunction

  function automatic logic [12:0] outs13();
    return {outs10(), good_trap, trap_cause};
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic set_in(logic [8:0] v);
    {stall, ifu_done, idu_done, idu_need_mem, idu_illegal,
     exu_done, ebreak, lsu_done, lsu_fault} = v;
  endtask

  // Two reset cycles, release at the following negedge: first INIT cycle.
  task automatic do_reset();
    rst = 1'b1; set_in(9'b0);
    step(2);
    rst = 1'b0;
    wb_seen = 0;
  endtask

  localparam logic [8:0] ALU  = 9'b011001010;
  localparam logic [8:0] LDD  = 9'b011101010;
  localparam logic [8:0] MW   = 9'b011001000;
  localparam logic [8:0] STL  = 9'b111001010;
  localparam logic [6:0] O_N  = 7'b0000000, O_F = 7'b1000000, O_D = 7'b0100000,
                         O_E  = 7'b0010000, O_M1 = 7'b0001010, O_M = 7'b0000010,
                         O_W  = 7'b0000100;

  initial begin
`ifdef STAGE_SEQ_PERF_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    // two ALU instructions, a load with three wait cycles, then a stall
    tbl[0]  = mk(ALU, 3'd0, O_N, 0);  tbl[1]  = mk(ALU, 3'd1, O_F, 0);
    tbl[2]  = mk(ALU, 3'd2, O_D, 0);  tbl[3]  = mk(ALU, 3'd3, O_E, 0);
    tbl[4]  = mk(ALU, 3'd5, O_W, 0);  tbl[5]  = mk(ALU, 3'd0, O_N, 1);
    tbl[6]  = mk(ALU, 3'd1, O_F, 1);  tbl[7]  = mk(ALU, 3'd2, O_D, 1);
    tbl[8]  = mk(ALU, 3'd3, O_E, 1);  tbl[9]  = mk(ALU, 3'd5, O_W, 1);
    tbl[10] = mk(ALU, 3'd0, O_N, 2);  tbl[11] = mk(ALU, 3'd1, O_F, 2);
    tbl[12] = mk(LDD, 3'd2, O_D, 2);  tbl[13] = mk(ALU, 3'd3, O_E, 2);
    tbl[14] = mk(MW,  3'd4, O_M1, 2); tbl[15] = mk(MW,  3'd4, O_M, 2);
    tbl[16] = mk(MW,  3'd4, O_M, 2);  tbl[17] = mk(ALU, 3'd4, O_M, 2);
    tbl[18] = mk(ALU, 3'd5, O_W, 2);  tbl[19] = mk(STL, 3'd0, O_N, 3);
    tbl[20] = mk(STL, 3'd0, O_N, 3);  tbl[21] = mk(ALU, 3'd0, O_N, 3);
    tbl[22] = mk(ALU, 3'd1, O_F, 3);

    // reset values, sampled while rst is still high
    rst = 1'b1; set_in(9'b0);
    step(2);
    chk("reset_outputs", outs13(), 0);
    chk("reset_cycle_cnt", cycle_cnt, 0);
    chk("reset_instret", instret, 0);

    // long stall in INIT: no fetch, cycle counter keeps running
    rst = 1'b0;
    set_in(STL);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_ifu_start_%0d", i), {state_o, ifu_start}, 0);
      chk($sformatf("stall_cycle_cnt_%0d", i), cycle_cnt, perf ? i : 0);
      step();
    end

    // main table
    do_reset();
    for (int r = 0; r < 23; r++) begin
      set_in(tbl[r].in);
      chk($sformatf("row%0d_outputs", r), outs10(), tbl[r].exp);
      chk($sformatf("row%0d_instret", r), instret, perf ? tbl[r].ret : 0);
      chk($sformatf("row%0d_cycle_cnt", r), cycle_cnt, perf ? r : 0);
      step();
    end

    // watchdog: exu_done never arrives -> halt after 15 EXEC cycles
    do_reset();
    set_in(9'b011000000);
    step(3);
    step(14);
    chk("wd_exec_cycle15_state", state_o, 3);
    step();
    chk("wd_timeout_status", {state_o, halted, good_trap, trap_cause}, {3'd6, 1'b1, 1'b0, 2'd3});
    chk("wd_timeout_no_wb", wb_seen, 0);

    // watchdog: done in the terminal cycle wins
    do_reset();
    set_in(9'b011000000);
    step(3);
    step(14);
    set_in(9'b011001000);
    chk("wd_late_done_state", state_o, 3);
    step();
    chk("wd_late_done_wb", {state_o, wb_en, halted}, {3'd5, 1'b1, 1'b0});

    // ebreak: good trap, no commit, cycle counter frozen
    do_reset();
    set_in(9'b011001100);
    step(4);
    chk("ebreak_status", {state_o, halted, good_trap, trap_cause}, {3'd6, 1'b1, 1'b1, 2'd0});
    chk("ebreak_cycle_cnt", cycle_cnt, perf ? 4 : 0);
    step(5);
    chk("ebreak_cycle_cnt_frozen", cycle_cnt, perf ? 4 : 0);
    chk("ebreak_still_halted", {state_o, halted}, {3'd6, 1'b1});
    chk("ebreak_no_wb", wb_seen, 0);

    // illegal opcode at decode
    do_reset();
    set_in(9'b011010000);
    step(3);
    chk("illegal_status", {state_o, halted, good_trap, trap_cause}, {3'd6, 1'b1, 1'b0, 2'd1});
    chk("illegal_no_wb", wb_seen, 0);

    // access fault in MEM
    do_reset();
    set_in(9'b011101011);
    step(5);
    chk("fault_status", {state_o, halted, good_trap, trap_cause}, {3'd6, 1'b1, 1'b0, 2'd2});
    chk("fault_no_wb", wb_seen, 0);

    // reset while halted: back to INIT, fetch resumes
    do_reset();
    chk("rst_from_halt_outputs", outs13(), 0);
    set_in(ALU);
    step();
    chk("rst_from_halt_fetch", {state_o, ifu_start}, {3'd1, 1'b1});

    // reset mid-instruction while in MEM
    do_reset();
    set_in(9'b011101000);
    step(4);
    chk("mid_mem_state", {state_o, mem_owner, lsu_start}, {3'd4, 1'b1, 1'b1});
    rst = 1'b1;
    step();
    chk("mid_reset_outputs", outs13(), 0);
    rst = 1'b0;
    set_in(9'b0);
    step();
    chk("mid_reset_no_wb", wb_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
